// File: rtl/wb_prefetch.sv
// Wishbone halfword prefetch queue feeding the decode stage.
// Optional bus-error halt when PREFETCH_BUSERR_EN is defined.
module wb_prefetch #(
  parameter int          DEPTH_LOG2 = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_tga_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
`ifdef PREFETCH_BUSERR_EN
  input  logic        wb_err_i,
  output logic        err_o,
`endif
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        rd_i,
  output logic        valid_o,
  output logic [15:0] insn_o,
  output logic [31:0] pc_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL =
    (DEPTH_LOG2+1)'(DEPTH);

`ifdef PREFETCH_BUSERR_EN
  typedef enum logic [1:0] {
    IDLE, FETCH, HALT
  } state_t;
`else
  typedef enum logic {
    IDLE, FETCH
  } state_t;
`endif

  state_t state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [15:0] insn_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic stb, push, pop, bus_err;

`ifdef PREFETCH_BUSERR_EN
  logic err_q, err_d;
  assign bus_err = stb & wb_err_i;
  assign err_o   = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign stb  = (state_q == FETCH);
  assign push = stb & wb_ack_i & ~flush_i & ~bus_err;
  assign pop  = rd_i & (cnt_q != '0) & ~flush_i;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q
            + {{DEPTH_LOG2{1'b0}}, push}
            - {{DEPTH_LOG2{1'b0}}, pop};
`ifdef PREFETCH_BUSERR_EN
    err_d = err_q;
`endif
    if (flush_i) begin
      state_d = IDLE;
      adr_d   = {flush_addr_i[31:1], 1'b0};
      cnt_d   = '0;
`ifdef PREFETCH_BUSERR_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_d < FULL) state_d = FETCH;
        end
        FETCH: begin
          if (bus_err) begin
`ifdef PREFETCH_BUSERR_EN
            state_d = HALT;
            err_d   = 1'b1;
`endif
          end else if (wb_ack_i) begin
            adr_d = adr_q + 32'd2;
            if (cnt_d == FULL) state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= {RESET_PC[31:1], 1'b0};
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
`ifdef PREFETCH_BUSERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
`ifdef PREFETCH_BUSERR_EN
      err_q   <= err_d;
`endif
      if (flush_i) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      insn_mem[wp_q] <= wb_dat_i[15:0];
      pc_mem[wp_q]   <= adr_q;
    end
  end

  assign valid_o  = (cnt_q != '0);
  assign insn_o   = valid_o ? insn_mem[rp_q] : '0;
  assign pc_o     = valid_o ? pc_mem[rp_q] : '0;

  assign wb_adr_o = adr_q;
  assign wb_stb_o = stb;
  assign wb_cyc_o = stb;
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 2'b11;
  assign wb_tga_o = 1'b0;

endmodule

// File: tb/tb_wb_prefetch.sv
// Directed bench for wb_prefetch with a queue scoreboard
// on the decode-side output stream.
module tb_wb_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, dat_i, dat_o;
  logic        we, tga, stb, cyc, ack;
  logic [1:0]  sel;
  logic        flush = 1'b0;
  logic [31:0] faddr = '0;
  logic        rd = 1'b0;
  logic        valid;
  logic [15:0] insn;
  logic [31:0] pc;
  logic        err_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  int ws = 0;
  int wcnt = 0;
  logic ack_en = 1'b1;
  logic err_en = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] insn;
  } ent_t;
  ent_t q[$];

  function automatic logic [15:0] rom(input logic [31:0] a);
    return a[16:1] ^ 16'h5A3C;
  endfunction

  always #5 clk = ~clk;

  assign dat_i = {16'hDEAD, rom(adr)};
  assign ack   = stb && (wcnt >= ws) && ack_en;
  assign err_i = stb && err_en;

  always @(posedge clk) begin
    if (stb && !ack) wcnt <= wcnt + 1;
    else             wcnt <= 0;
  end

  wb_prefetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb_adr_o     (adr),
    .wb_dat_i     (dat_i),
    .wb_dat_o     (dat_o),
    .wb_we_o      (we),
    .wb_sel_o     (sel),
    .wb_tga_o     (tga),
    .wb_stb_o     (stb),
    .wb_cyc_o     (cyc),
    .wb_ack_i     (ack),
`ifdef PREFETCH_BUSERR_EN
    .wb_err_i     (err_i),
    .err_o        (err_o),
`endif
    .flush_i      (flush),
    .flush_addr_i (faddr),
    .rd_i         (rd),
    .valid_o      (valid),
    .insn_o       (insn),
    .pc_o         (pc)
  );

`ifndef PREFETCH_BUSERR_EN
  assign err_o = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!stb && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, stb}, 32'd1);
  endtask

  // Scoreboard: head check, then apply the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", {31'b0, valid},
          {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("head_pc", pc, q[0].pc);
        chk("head_insn", {16'b0, insn},
            {16'b0, q[0].insn});
      end
      if (flush) begin
        q.delete();
      end else begin
        if (rd && q.size() != 0) void'(q.pop_front());
        if (stb && ack && !err_i)
          q.push_back('{pc: adr, insn: rom(adr)});
      end
    end
  end

  initial begin
    logic [31:0] e;
    logic [31:0] held;
    int n;

    tick(); tick(); tick();
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_insn", {16'b0, insn}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_adr", adr, 32'h1000);
    chk("tie_dat", dat_o, 32'd0);
    chk("tie_we", {31'b0, we}, 32'd0);
    chk("tie_sel", {30'b0, sel}, 32'd3);
    chk("tie_tga", {31'b0, tga}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_stb", {31'b0, stb}, 32'd1);
      chk("fill_adr", adr, 32'h1000 + 32'(2*i));
      if (i == 0) chk("lat_v0", {31'b0, valid}, 32'd0);
      if (i == 1) chk("lat_v1", {31'b0, valid}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_stb", {31'b0, stb}, 32'd0);
      chk("full_pc", pc, 32'h1000);
    end

    rd = 1'b1;
    e = 32'h1000;
    for (int i = 0; i < 10; i++) begin
      chk("stream_pc", pc, e);
      tick();
      e = e + 32'd2;
    end
    rd = 1'b0;

    ws = 3;
    n = 0;
    while (stb && n < 40) begin
      tick();
      n++;
    end
    chk("ws_full", {31'b0, stb}, 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("ws_resume", {31'b0, stb}, 32'd1);
    held = adr;
    n = 0;
    while (stb && n < 10) begin
      chk("ws_adr_hold", adr, held);
      tick();
      n++;
    end
    chk("ws_cycles", n, 32'd4);
    ws = 0;

    rd = 1'b1;
    wait_stb("pre_flush_stb");
    tick(); tick();
    chk("flush_ack", {31'b0, ack}, 32'd1);
    flush = 1'b1;
    faddr = 32'h2003;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'b0, valid}, 32'd0);
    chk("flush_stb", {31'b0, stb}, 32'd0);
    wait_stb("flush_restart");
    chk("flush_adr", adr, 32'h2002);
    tick(); tick(); tick();

    flush = 1'b1;
    faddr = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    wait_stb("wrap_stb");
    chk("wrap_adr0", adr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_adr1", adr, 32'hFFFF_FFFE);
    tick();
    chk("wrap_adr2", adr, 32'h0000_0000);
    chk("wrap_stb2", {31'b0, stb}, 32'd1);
    tick(); tick();

`ifdef PREFETCH_BUSERR_EN
    rd = 1'b0;
    flush = 1'b1;
    faddr = 32'h1000;
    tick();
    flush = 1'b0;
    n = 0;
    while (!(stb && adr == 32'h1004) && n < 10) begin
      tick();
      n++;
    end
    chk("err_third", adr, 32'h1004);
    err_en = 1'b1;
    ack_en = 1'b0;
    tick();
    err_en = 1'b0;
    ack_en = 1'b1;
    chk("err_set", {31'b0, err_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stb", {31'b0, stb}, 32'd0);
    end
    chk("halt_pc", pc, 32'h1000);
    rd = 1'b1;
    tick();
    chk("halt_pc2", pc, 32'h1002);
    tick();
    rd = 1'b0;
    chk("halt_empty", {31'b0, valid}, 32'd0);
    chk("halt_stb2", {31'b0, stb}, 32'd0);
    flush = 1'b1;
    faddr = 32'h1000;
    tick();
    flush = 1'b0;
    chk("err_clr", {31'b0, err_o}, 32'd0);
    wait_stb("err_resume");
    chk("err_adr", adr, 32'h1000);
    tick(); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
